// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types: opcodes, words, control packet, MEM-stage states
//   lc3b_word       16-bit datapath word
//   lc3b_opcode     4-bit instruction opcode (op_* constants)
//   lc3b_ipacket    control packet carried down the pipe
//   lc3b_mem_state  MEM-stage access sequencer states
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef struct packed {
    lc3b_word   pc;
    logic [2:0] dest;
    logic       load_regfile;
    logic       load_cc;
  } lc3b_ipacket;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } lc3b_mem_state;

  function automatic logic is_mem_op(input lc3b_opcode op);
    return op inside {op_ldr, op_str, op_ldb, op_stb, op_ldi, op_sti, op_trap};
  endfunction

  function automatic logic is_store_op(input lc3b_opcode op);
    return op inside {op_str, op_stb, op_sti};
  endfunction

  function automatic logic is_indirect_op(input lc3b_opcode op);
    return op inside {op_ldi, op_sti};
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - byte/word lane steering for loads and stores
//   opcode      in   instruction opcode
//   addr_lsb    in   bit 0 of the unmasked access address (byte select)
//   rdata       in   raw data-memory read word
//   store_data  in   SR value to be stored
//   load_data   out  LDB sign-extended byte, word for other loads, 0 for stores
//   wmask       out  byte write enables
//   wdata       out  write data with the byte replicated on both lanes for STB
module mem_load_align
  import lc3b_types::*;
(
  input  lc3b_opcode opcode,
  input  logic       addr_lsb,
  input  lc3b_word   rdata,
  input  lc3b_word   store_data,
  output lc3b_word   load_data,
  output logic [1:0] wmask,
  output lc3b_word   wdata
);

  logic [7:0] sel_byte;

  assign sel_byte = addr_lsb ? rdata[15:8] : rdata[7:0];

  always_comb begin
    load_data = rdata;
    if (opcode == op_ldb) begin
      load_data = {{8{sel_byte[7]}}, sel_byte};
    end else if (is_store_op(opcode)) begin
      load_data = 16'h0;
    end
  end

  always_comb begin
    wmask = 2'b11;
    wdata = store_data;
    if (opcode == op_stb) begin
      // Replicating the byte lets memory pick either lane with the mask alone.
      wmask = addr_lsb ? 2'b10 : 2'b01;
      wdata = {store_data[7:0], store_data[7:0]};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - LC-3b MEM stage: data-memory access sequencing with stall generation
//   clk, reset         pipeline clock, asynchronous active-high reset
//   ex_valid, opcode   EX/MEM instruction valid and opcode
//   alu_in             effective address (memory ops) or ALU result
//   store_data         SR value for stores
//   ipacket_in/out     control packet, passed through
//   pipe_hold          downstream freeze; final result is parked in DONE while high
//   dmem_*             data-memory request/response interface
//   mem_stall          stage busy, upstream must hold
//   mem_data           load/TRAP result, mem_address final unmasked address
//   alu_out            alu_in passed through
module mem_stage
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  lc3b_opcode  opcode,
  input  lc3b_word    alu_in,
  input  lc3b_word    store_data,
  input  lc3b_ipacket ipacket_in,
  input  logic        pipe_hold,
  input  lc3b_word    dmem_rdata,
  input  logic        dmem_resp,
  output lc3b_word    dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_wmask,
  output lc3b_word    dmem_wdata,
  output logic        mem_stall,
  output lc3b_word    mem_data,
  output lc3b_word    mem_address,
  output lc3b_word    alu_out,
  output lc3b_ipacket ipacket_out
);

  lc3b_mem_state state_q, state_d;
  lc3b_word      ind_q, ind_d;
  lc3b_word      result_q, result_d;

  logic     mem_op, ind_op, store_op;
  logic     req_active, in_access, resp_ok, final_acc;
  lc3b_word acc_addr, load_data;

  assign mem_op   = ex_valid && is_mem_op(opcode);
  assign ind_op   = is_indirect_op(opcode);
  assign store_op = is_store_op(opcode);

  // The pointer fetched by the first indirect access stays the address of
  // record for the rest of the instruction, including while parked in DONE.
  assign acc_addr  = (ind_op && (state_q == ACC2 || state_q == DONE)) ? ind_q : alu_in;
  assign in_access = (state_q == ACC1) || (state_q == ACC2);
  // IDLE issues the request the same cycle the op arrives; reset kills it at once.
  assign req_active = !reset && mem_op && (state_q != DONE);
  // A response only counts once the sequencer has registered the request.
  assign resp_ok   = req_active && in_access && dmem_resp;
  assign final_acc = !ind_op || (state_q == ACC2);

  mem_load_align u_align (
    .opcode     (opcode),
    .addr_lsb   (acc_addr[0]),
    .rdata      (dmem_rdata),
    .store_data (store_data),
    .load_data  (load_data),
    .wmask      (dmem_wmask),
    .wdata      (dmem_wdata)
  );

  always_comb begin
    // STI reads its pointer first; only its final access is a write.
    dmem_write   = req_active && store_op && final_acc;
    dmem_read    = req_active && !(store_op && final_acc);
    dmem_address = {acc_addr[15:1], 1'b0};
    mem_stall    = req_active && !(resp_ok && final_acc);
    mem_address  = acc_addr;
    alu_out      = alu_in;
    ipacket_out  = ipacket_in;
    mem_data     = 16'h0;
    if (state_q == DONE) begin
      mem_data = result_q;
    end else if (resp_ok && final_acc) begin
      mem_data = load_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    ind_d    = ind_q;
    result_d = result_q;
    if (resp_ok && final_acc) begin
      result_d = load_data;
    end
    case (state_q)
      IDLE: if (mem_op) state_d = ACC1;
      ACC1: begin
        if (!mem_op) begin
          state_d = IDLE;
        end else if (resp_ok) begin
          if (ind_op) begin
            state_d = ACC2;
            ind_d   = dmem_rdata;
          end else begin
            state_d = pipe_hold ? DONE : IDLE;
          end
        end
      end
      ACC2: begin
        if (!mem_op) begin
          state_d = IDLE;
        end else if (resp_ok) begin
          state_d = pipe_hold ? DONE : IDLE;
        end
      end
      DONE:    if (!pipe_hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ind_q    <= 16'h0;
      result_q <= 16'h0;
    end else begin
      state_q  <= state_d;
      ind_q    <= ind_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage against a behavioural memory model
module tb_mem_stage;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  lc3b_opcode  opcode;
  lc3b_word    alu_in;
  lc3b_word    store_data;
  lc3b_ipacket ipacket_in;
  logic        pipe_hold;
  lc3b_word    dmem_rdata;
  logic        dmem_resp;
  lc3b_word    dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [1:0]  dmem_wmask;
  lc3b_word    dmem_wdata;
  logic        mem_stall;
  lc3b_word    mem_data;
  lc3b_word    mem_address;
  lc3b_word    alu_out;
  lc3b_ipacket ipacket_out;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [logic [15:0]];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .opcode       (opcode),
    .alu_in       (alu_in),
    .store_data   (store_data),
    .ipacket_in   (ipacket_in),
    .pipe_hold    (pipe_hold),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .mem_stall    (mem_stall),
    .mem_data     (mem_data),
    .mem_address  (mem_address),
    .alu_out      (alu_out),
    .ipacket_out  (ipacket_out)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'hA55A;
  endfunction

  // Memory behaviour: word-addressed, bytes selected by address bit 0.
  task automatic mem_store(input lc3b_opcode op, input logic [15:0] a, input logic [15:0] sd);
    logic [15:0] w;
    w = mem_rd({a[15:1], 1'b0});
    if (op == op_stb) begin
      if (a[0]) w[15:8] = sd[7:0];
      else      w[7:0]  = sd[7:0];
    end else begin
      w = sd;
    end
    mem[{a[15:1], 1'b0}] = w;
  endtask

  // One memory instruction: lat1/lat2 are the cycles each access waits before
  // its response (first access needs >= 1), hold is the number of cycles the
  // result is parked by pipe_hold.
  task automatic run_op(input lc3b_opcode op, input logic [15:0] addr, input logic [15:0] sd,
                        input int lat1, input int lat2, input int hold);
    logic [15:0] acc_a [2];
    logic [15:0] ptr, fbyte, w, exp_data, exp_wdata;
    logic [1:0]  exp_wmask;
    logic [7:0]  b;
    lc3b_ipacket ipk;
    logic        ind, st, last, wr, resp;
    int          n_acc, lat;
    string       nm;

    nm    = op.name();
    ind   = (op == op_ldi) || (op == op_sti);
    st    = (op == op_str) || (op == op_stb) || (op == op_sti);
    n_acc = ind ? 2 : 1;
    acc_a[0] = {addr[15:1], 1'b0};
    ptr   = mem_rd(acc_a[0]);
    acc_a[1] = {ptr[15:1], 1'b0};
    fbyte = ind ? ptr : addr;
    w     = mem_rd(acc_a[n_acc-1]);
    b     = fbyte[0] ? w[15:8] : w[7:0];
    if (st)               exp_data = 16'h0;
    else if (op == op_ldb) exp_data = {{8{b[7]}}, b};
    else                  exp_data = w;
    exp_wmask = (op == op_stb) ? (fbyte[0] ? 2'b10 : 2'b01) : 2'b11;
    exp_wdata = (op == op_stb) ? {sd[7:0], sd[7:0]} : sd;
    ipk = lc3b_ipacket'(21'($urandom));

    for (int k = 0; k < n_acc; k++) begin
      last = (k == n_acc - 1);
      wr   = st && last;
      lat  = (k == 0) ? lat1 : lat2;
      for (int c = 0; c <= lat; c++) begin
        @(negedge clk);
        resp       = (c == lat);
        ex_valid   = 1'b1;
        opcode     = op;
        alu_in     = addr;
        store_data = sd;
        ipacket_in = ipk;
        dmem_resp  = resp;
        dmem_rdata = resp ? mem_rd(acc_a[k]) : 16'($urandom);
        pipe_hold  = (resp && last) ? (hold > 0) : 1'($urandom_range(0, 1));
        #1;
        chk ({nm, "_daddr"}, dmem_address, acc_a[k]);
        chkb({nm, "_read"},  dmem_read, !wr);
        chkb({nm, "_write"}, dmem_write, wr);
        chkb({nm, "_stall"}, mem_stall, !(resp && last));
        chk ({nm, "_alu_out"}, alu_out, addr);
        if (wr) begin
          chk({nm, "_wmask"}, {14'b0, dmem_wmask}, {14'b0, exp_wmask});
          chk({nm, "_wdata"}, dmem_wdata, exp_wdata);
        end
        if (resp && last) begin
          chk({nm, "_mem_data"}, mem_data, exp_data);
          chk({nm, "_mem_address"}, mem_address, fbyte);
          chk({nm, "_ipk_pc"}, ipacket_out.pc, ipk.pc);
          chk({nm, "_ipk_ctl"}, {11'b0, ipacket_out.dest, ipacket_out.load_regfile, ipacket_out.load_cc},
                                {11'b0, ipk.dest, ipk.load_regfile, ipk.load_cc});
          if (wr) mem_store(op, fbyte, sd);
        end
      end
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      dmem_resp  = 1'b0;
      dmem_rdata = 16'($urandom);
      pipe_hold  = (h < hold - 1);
      #1;
      chkb({nm, "_done_read"},  dmem_read, 1'b0);
      chkb({nm, "_done_write"}, dmem_write, 1'b0);
      chkb({nm, "_done_stall"}, mem_stall, 1'b0);
      chk ({nm, "_done_data"},  mem_data, exp_data);
      chk ({nm, "_done_addr"},  mem_address, fbyte);
    end
  endtask

  task automatic run_nonmem(input lc3b_opcode op, input logic valid, input logic [15:0] addr);
    @(negedge clk);
    ex_valid   = valid;
    opcode     = op;
    alu_in     = addr;
    store_data = 16'($urandom);
    dmem_resp  = 1'($urandom_range(0, 1));
    dmem_rdata = 16'($urandom);
    pipe_hold  = 1'($urandom_range(0, 1));
    #1;
    chkb("idle_read",  dmem_read, 1'b0);
    chkb("idle_write", dmem_write, 1'b0);
    chkb("idle_stall", mem_stall, 1'b0);
    chk ("idle_mem_data", mem_data, 16'h0);
    chk ("idle_mem_address", mem_address, addr);
    chk ("idle_alu_out", alu_out, addr);
  endtask

  initial begin
    lc3b_opcode op;
    logic [15:0] a;

    reset      = 1'b1;
    ex_valid   = 1'b1;
    opcode     = op_ldr;
    alu_in     = 16'h3001;
    store_data = 16'h0;
    ipacket_in = '0;
    pipe_hold  = 1'b0;
    dmem_rdata = 16'h0;
    dmem_resp  = 1'b0;

    // Reset state: memory op present but nothing issued.
    @(negedge clk);
    #1;
    chkb("rst_read", dmem_read, 1'b0);
    chkb("rst_write", dmem_write, 1'b0);
    chkb("rst_stall", mem_stall, 1'b0);
    chk ("rst_mem_data", mem_data, 16'h0);

    // Reset in the middle of an LDR access.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chkb("ldr_pre_read", dmem_read, 1'b1);
    chkb("ldr_pre_stall", mem_stall, 1'b1);
    @(negedge clk);
    #1;
    chkb("acc1_read", dmem_read, 1'b1);
    reset = 1'b1;
    #1;
    chkb("midrst_read", dmem_read, 1'b0);
    chkb("midrst_stall", mem_stall, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    dmem_resp = 1'b1;
    dmem_rdata = 16'h1234;
    #1;
    chkb("late_resp_stall", mem_stall, 1'b0);
    chk ("late_resp_data", mem_data, 16'h0);

    // Directed cases.
    mem[16'h3000] = 16'hBEEF;
    run_op(op_ldr, 16'h3001, 16'h0, 3, 0, 0);
    run_op(op_stb, 16'h4005, 16'h12A5, 2, 0, 0);
    mem[16'h2000] = 16'h0080;
    run_op(op_ldb, 16'h2000, 16'h0, 1, 0, 0);
    run_op(op_ldb, 16'h2001, 16'h0, 2, 0, 0);
    mem[16'h1000] = 16'h5000;
    mem[16'h5000] = 16'h7777;
    run_op(op_ldi, 16'h1000, 16'h0, 2, 2, 0);
    run_op(op_ldr, 16'h3000, 16'h0, 1, 0, 2);
    run_nonmem(op_add, 1'b1, 16'h0042);
    run_op(op_sti, 16'h1000, 16'hCAFE, 1, 0, 1);
    run_op(op_ldr, 16'h5000, 16'h0, 1, 0, 0);
    run_op(op_trap, 16'h0025, 16'h0, 1, 0, 0);
    run_nonmem(op_ldr, 1'b0, 16'h0777);

    // Randomized mix over a small address window so stores feed later loads.
    for (int i = 0; i < 60; i++) begin
      op = lc3b_opcode'(4'($urandom));
      a  = 16'h0800 + 16'($urandom_range(0, 15));
      if (op inside {op_ldr, op_str, op_ldb, op_stb, op_ldi, op_sti, op_trap}) begin
        if ($urandom_range(0, 7) == 0)
          run_nonmem(op, 1'b0, a);
        else
          run_op(op, a, 16'($urandom), $urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        run_nonmem(op, 1'b1, 16'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
MEM stage of the pipelined LC-3b core. It sits between the EX/MEM register and mem_wb_meat, and performs the data-memory access for the memory opcodes. LDR, STR, LDB, STB and TRAP take one access; LDI and STI take two. It drives mem_stall back to the hazard unit until its results are valid, and presents mem_data, mem_address, alu_out and ipacket to mem_wb_meat.

Parameters:
None.

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  EX/MEM holds a valid instruction
opcode  in  4  lc3b_opcode of that instruction
alu_in  in  16  effective address for memory ops; ALU result otherwise
store_data  in  16  SR value for STR/STB/STI
ipacket_in  in  lc3b_ipacket  control packet, passed through
pipe_hold  in  1  global freeze from a later stage; downstream is not accepting
dmem_rdata  in  16  data-memory read data
dmem_resp  in  1  data-memory response, 1 cycle per access
dmem_address  out  16  data-memory address
dmem_read  out  1  read request
dmem_write  out  1  write request
dmem_wmask  out  2  byte write enables
dmem_wdata  out  16  write data
mem_stall  out  1  MEM stage busy; upstream must hold
mem_data  out  16  load/TRAP result to mem_wb_meat
mem_address  out  16  address of the final access
alu_out  out  16  alu_in passed through
ipacket_out  out  lc3b_ipacket  ipacket_in passed through

Behaviour:
- Memory ops are LDR, STR, LDB, STB, LDI, STI and TRAP, with ex_valid=1. All other opcodes, or ex_valid=0:
  - no request issued; mem_stall=0;
  - mem_data=16'h0; mem_address=alu_in.
- FSM states and outputs:
  - IDLE: no access in flight.
  - ACC1: first access. Request drives address alu_in.
  - ACC2: indirect access for LDI/STI. Request drives address ind_q.
  - DONE: result held while pipe_hold is high.
- Requests are combinational from state and inputs. A request stays asserted until dmem_resp.
- Transitions:
  - IDLE -> ACC1 when a memory op arrives. The request is driven in the same cycle the op arrives (IDLE behaves as ACC1 for outputs).
  - ACC1 + resp, LDI/STI -> ACC2; ind_q <= dmem_rdata.
  - ACC1 + resp, other ops -> DONE if pipe_hold=1, else IDLE.
  - ACC2 + resp -> DONE if pipe_hold=1, else IDLE.
  - DONE -> IDLE when pipe_hold=0. No re-issue while in DONE.
- mem_stall:
  - 1 whenever a request is outstanding and this is not the final dmem_resp cycle.
  - 0 on the final resp cycle, so the result is captured at that edge.
  - 0 in DONE.
  - LDI/STI stall through the first resp.
- Address and mask rules:
  - Word access: dmem_address={addr[15:1],1'b0}; wmask=2'b11; wdata=store_data.
  - Byte access (LDB/STB): dmem_address={addr[15:1],1'b0}.
  - STB: wmask = addr[0] ? 2'b10 : 2'b01; wdata={store_data[7:0],store_data[7:0]}.
  - LDB: mem_data = SEXT(addr[0] ? rdata[15:8] : rdata[7:0]).
  - LDR, LDI and TRAP: mem_data = full word. LDI uses the second-access word.
  - Stores: mem_data=16'h0.
- mem_address = unmasked final access address (alu_in, or ind_q for LDI/STI).
- Result register: on the final resp, result_q <= processed data.
  - In DONE: mem_data=result_q.
  - On the resp cycle: mem_data = processed dmem_rdata (bypass).
- Reset (asynchronous), including mid-access:
  - state=IDLE; ind_q=16'h0; result_q=16'h0.
  - Request outputs drop immediately; mem_stall=0.
  - A late dmem_resp arriving in IDLE is ignored.
- Simultaneous resp and pipe_hold=1: go to DONE and capture result_q. mem_stall=0.

Decomposition:
- lc3b_types holds:
  - lc3b_opcode and its op_* constants;
  - lc3b_word and lc3b_ipacket;
  - a new enum lc3b_mem_state {IDLE, ACC1, ACC2, DONE}.
- Sub-module mem_load_align: combinational.
  - Inputs: opcode, addr[0], rdata.
  - Outputs: load data (LDB sign-extend / word).
  - Also computes wmask and wdata.

Test Plan:
- Reset: reset=1 during ACC1 of an LDR -> dmem_read=0 and mem_stall=0 immediately; state=IDLE.
- LDR, alu_in=16'h3001, memory word 16'hBEEF, resp after 3 cycles:
  - dmem_address=16'h3000;
  - mem_stall high for 3 cycles, low on the resp cycle;
  - mem_data=16'hBEEF.
- STB, alu_in=16'h4005, store_data=16'h12A5 -> dmem_wmask=2'b10, dmem_wdata=16'hA5A5, dmem_write=1 until resp.
- LDB, alu_in=16'h2000, rdata=16'h0080 -> mem_data=16'hFF80. Repeat with alu_in=16'h2001 -> mem_data=16'h0000.
- LDI, alu_in=16'h1000, mem[16'h1000]=16'h5000, mem[16'h5000]=16'h7777:
  - two reads, 16'h1000 then 16'h5000;
  - mem_stall stays high across the first resp;
  - mem_data=16'h7777; mem_address=16'h5000.
- LDR completes with pipe_hold=1 for 2 cycles:
  - state DONE; no second dmem_read;
  - mem_data held at the result; mem_stall=0;
  - returns to IDLE when pipe_hold=0.
- ADD (non-memory op), alu_in=16'h0042 -> no request; mem_stall=0; alu_out=16'h0042; mem_data=16'h0000.
